// File: rtl/voxel_grid_reader_pkg.sv
// Shared definitions for the voxel grid reader: voxel word field offsets, feature word
// layout, arithmetic widths and the scan FSM state encoding.
// Optional build macro: VGR_CLEAR_ON_READ_EN adds the StClear state.
package voxel_grid_reader_pkg;

   localparam int unsigned COUNT_BITS = 8;
   localparam int unsigned SUM_BITS   = 24;
   localparam int unsigned COORD_BITS = 10;
   localparam int unsigned INDEX_BITS = 15;

   // Voxel word: [79:72] count, [71:48] sumX, [47:24] sumY, [23:0] sumZ
   localparam int unsigned VOXEL_BITS = COUNT_BITS + 3 * SUM_BITS;
   localparam int unsigned SUMZ_LSB   = 0;
   localparam int unsigned SUMY_LSB   = SUMZ_LSB + SUM_BITS;
   localparam int unsigned SUMX_LSB   = SUMY_LSB + SUM_BITS;
   localparam int unsigned COUNT_LSB  = SUMX_LSB + SUM_BITS;

   // Feature word: {index, count, meanX, meanY, meanZ}
   localparam int unsigned FEAT_BITS       = INDEX_BITS + COUNT_BITS + 3 * COORD_BITS;
   localparam int unsigned FEAT_MEANZ_LSB  = 0;
   localparam int unsigned FEAT_MEANY_LSB  = FEAT_MEANZ_LSB + COORD_BITS;
   localparam int unsigned FEAT_MEANX_LSB  = FEAT_MEANY_LSB + COORD_BITS;
   localparam int unsigned FEAT_COUNT_LSB  = FEAT_MEANX_LSB + COORD_BITS;
   localparam int unsigned FEAT_INDEX_LSB  = FEAT_COUNT_LSB + COUNT_BITS;

   localparam logic [COORD_BITS-1:0] MEAN_MAX = '1;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWait,
      StCheck,
      StDiv,
      StOut,
      StDone
`ifdef VGR_CLEAR_ON_READ_EN
      , StClear
`endif
   } state_e;

   // Clamp a full-width quotient to the feature coordinate range.
   function automatic logic [COORD_BITS-1:0] sat_mean(input logic [SUM_BITS-1:0] q);
      return (|q[SUM_BITS-1:COORD_BITS]) ? MEAN_MAX : q[COORD_BITS-1:0];
   endfunction

endpackage

// File: rtl/voxel_mean_div.sv
// Sequential restoring divider: 24-bit dividend / 8-bit divisor, one quotient bit per
// cycle. done is high during the 24th iteration; quotient is final the cycle after.
module voxel_mean_div
   import voxel_grid_reader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SUM_BITS-1:0]   dividend,
   input  logic [COUNT_BITS-1:0] divisor,
   output logic                  done,
   output logic [SUM_BITS-1:0]   quotient
);

   logic [SUM_BITS-1:0]   quo_q, quo_d;
   logic [COUNT_BITS-1:0] rem_q, rem_d;
   logic [COUNT_BITS-1:0] dvs_q, dvs_d;
   logic [4:0]            cnt_q, cnt_d;
   logic                  run_q, run_d;
   logic [COUNT_BITS:0]   trial;
   logic [COUNT_BITS:0]   diff;

   // Next-state: load on start, else shift one dividend bit into the remainder per cycle.
   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      run_d = run_q;
      trial = {rem_q, quo_q[SUM_BITS-1]};
      diff  = trial - {1'b0, dvs_q};
      if (start) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         // trial < 2*divisor, so a successful subtraction always fits in COUNT_BITS
         if (trial >= {1'b0, dvs_q}) begin
            rem_d = diff[COUNT_BITS-1:0];
            quo_d = {quo_q[SUM_BITS-2:0], 1'b1};
         end else begin
            rem_d = trial[COUNT_BITS-1:0];
            quo_d = {quo_q[SUM_BITS-2:0], 1'b0};
         end
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'(SUM_BITS - 1)) run_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign done     = run_q && (cnt_q == 5'(SUM_BITS - 1));
   assign quotient = quo_q;

endmodule

// File: rtl/voxel_grid_reader.sv
// Scans every voxel of the BRAM grid in ascending address order and emits one feature
// (index, count, per-axis mean) for every non-empty voxel over a valid/ready port.
// Optional build macro: VGR_CLEAR_ON_READ_EN zeroes each voxel after it has been read.
module voxel_grid_reader
   import voxel_grid_reader_pkg::*;
#(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     bram_addr,
   output logic                  bram_re,
   input  logic [VOXEL_BITS-1:0] bram_data_in,
   output logic                  bram_we,
   output logic [VOXEL_BITS-1:0] bram_data_out,
   output logic                  feat_valid,
   input  logic                  feat_ready,
   output logic [FEAT_BITS-1:0]  feat_data,
   output logic [15:0]           feat_cnt
);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [1:0]              wait_q, wait_d;
   logic [VOXEL_BITS-1:0]   vox_q, vox_d;
   logic [15:0]             feat_cnt_q, feat_cnt_d;
   logic                    adv;
   logic                    div_start;
   logic                    done_x, done_y, done_z;
   logic [SUM_BITS-1:0]     quo_x, quo_y, quo_z;
   logic [COUNT_BITS-1:0]   vox_count;

   assign vox_count = vox_q[COUNT_LSB +: COUNT_BITS];
   assign div_start = (state_q == StCheck) && (vox_count != '0);

   voxel_mean_div u_div_x (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (vox_q[SUMX_LSB +: SUM_BITS]),
      .divisor  (vox_count),
      .done     (done_x),
      .quotient (quo_x)
   );

   voxel_mean_div u_div_y (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (vox_q[SUMY_LSB +: SUM_BITS]),
      .divisor  (vox_count),
      .done     (done_y),
      .quotient (quo_y)
   );

   voxel_mean_div u_div_z (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (vox_q[SUMZ_LSB +: SUM_BITS]),
      .divisor  (vox_count),
      .done     (done_z),
      .quotient (quo_z)
   );

   // Next-state and datapath updates for the scan FSM.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wait_d     = wait_q;
      vox_d      = vox_q;
      feat_cnt_d = feat_cnt_q;
      adv        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StRead;
               addr_d     = '0;
               feat_cnt_d = '0;
            end
         end
         StRead: begin
            state_d = StWait;
            wait_d  = '0;
         end
         StWait: begin
            if (wait_q == 2'(READ_LAT - 1)) begin
               vox_d   = bram_data_in;
               state_d = StCheck;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         StCheck: begin
            if (vox_count != '0) begin
               state_d = StDiv;
            end else begin
`ifdef VGR_CLEAR_ON_READ_EN
               state_d = StClear;
`else
               adv = 1'b1;
`endif
            end
         end
         StDiv: begin
            if (done_x && done_y && done_z) state_d = StOut;
         end
         StOut: begin
            if (feat_ready) begin
               if (feat_cnt_q != '1) feat_cnt_d = feat_cnt_q + 16'd1;
`ifdef VGR_CLEAR_ON_READ_EN
               state_d = StClear;
`else
               adv = 1'b1;
`endif
            end
         end
`ifdef VGR_CLEAR_ON_READ_EN
         StClear: adv = 1'b1;
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Move to the next voxel, or finish after the last address of the grid.
      if (adv) begin
         if (addr_q == '1) begin
            state_d = StDone;
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRead;
         end
      end
   end

   // State and datapath registers; reset abandons any scan in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wait_q     <= '0;
         vox_q      <= '0;
         feat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wait_q     <= wait_d;
         vox_q      <= vox_d;
         feat_cnt_q <= feat_cnt_d;
      end
   end

   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign bram_re       = (state_q == StRead);
   assign bram_addr     = addr_q;
   assign bram_data_out = '0;
`ifdef VGR_CLEAR_ON_READ_EN
   assign bram_we       = (state_q == StClear);
`else
   assign bram_we       = 1'b0;
`endif
   assign feat_valid    = (state_q == StOut);
   assign feat_cnt      = feat_cnt_q;
   // Only sampled in StOut, where all inputs to this word are held stable.
   assign feat_data     = {INDEX_BITS'(addr_q), vox_count,
                           sat_mean(quo_x), sat_mean(quo_y), sat_mean(quo_z)};

endmodule

// File: doc/voxel_grid_reader.md
VOXEL_GRID_READER -- requirements
Module: voxel_grid_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, meaning voxel BRAM address width (32^3 grid, index = {vx,vy,vz}).
REQ-002 The block SHALL have parameter READ_LAT, default 1, meaning BRAM read latency in cycles (legal values 1 or 2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to scan the whole grid.
REQ-006 The block SHALL have port busy  output  1  high while a scan is in progress.
REQ-007 The block SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-008 The block SHALL have port bram_addr  output  ADDR_W  BRAM read/write address.
REQ-009 The block SHALL have port bram_re  output  1  BRAM read strobe.
REQ-010 The block SHALL have port bram_data_in  input  80  read data: [79:72] count, [71:48] sumX, [47:24] sumY, [23:0] sumZ.
REQ-011 The block SHALL have port bram_we  output  1  BRAM write enable (clear feature only).
REQ-012 The block SHALL have port bram_data_out  output  80  BRAM write data (all zero).
REQ-013 The block SHALL have port feat_valid  output  1  feature word valid.
REQ-014 The block SHALL have port feat_ready  input  1  downstream accepts feature.
REQ-015 The block SHALL have port feat_data  output  53  {index[52:38], count[37:30], meanX[29:20], meanY[19:10], meanZ[9:0]}.
REQ-016 The block SHALL have port feat_cnt  output  16  number of features emitted in the current/last scan.

Function
REQ-017 FSM states SHALL be IDLE, READ, WAIT, CHECK, DIV, OUT, CLEAR, DONE.
- IDLE->READ on start; address=0, feat_cnt=0.
- READ: bram_re=1 for one cycle at current address -> WAIT.
- WAIT: hold READ_LAT cycles, then capture bram_data_in -> CHECK.
- CHECK: count==0 -> advance; else -> DIV.
REQ-018 DIV SHALL compute meanX/Y/Z = floor(sum/count) with three parallel 24-bit/8-bit restoring dividers, exactly 24 cycles, then -> OUT.
REQ-019 Each mean SHALL saturate to 1023 when the quotient exceeds 10 bits.
REQ-020 OUT SHALL hold feat_valid=1 with feat_data stable until feat_valid&&feat_ready; on that cycle feat_cnt SHALL increment (saturating at 65535).
REQ-021 Advance SHALL be: address==2^ADDR_W-1 -> DONE, else address+1 -> READ.
REQ-022 DONE SHALL pulse done for one cycle, then -> IDLE.
REQ-023 start while busy SHALL be ignored.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Features SHALL be emitted in strictly ascending index order; empty voxels SHALL never be emitted.
REQ-026 Outside READ, bram_re SHALL be 0; bram_addr SHALL hold its last value.

Reset
REQ-027 On rst_n low, the block SHALL enter IDLE asynchronously.
REQ-028 Reset values SHALL be busy=0, done=0, feat_valid=0, bram_re=0, bram_we=0, bram_addr=0, bram_data_out=0, feat_data=0, feat_cnt=0.
REQ-029 Reset mid-scan SHALL abandon the scan with no done pulse.

Configuration
REQ-030 With VGR_CLEAR_ON_READ_EN defined, after each CHECK (empty or not, after OUT if non-empty) the FSM SHALL pass through CLEAR, asserting bram_we=1 for one cycle with bram_data_out=0 at the same address.
REQ-031 Without VGR_CLEAR_ON_READ_EN, the CLEAR state SHALL be absent and bram_we SHALL be constant 0.

Structure
REQ-032 A shared package SHALL hold voxel field offsets (COUNT/SUMX/SUMY/SUMZ slices), COUNT_BITS=8, SUM_BITS=24, COORD_BITS=10, the feature word layout, and the FSM state enum.
REQ-033 One sub-module, voxel_mean_div (24-bit/8-bit sequential restoring divider with start/done), SHALL be instantiated three times.

Verification
REQ-034 The bench SHALL cover these scenarios:
- All-zero BRAM, start -> no feat_valid, done after ~2^15*(2+READ_LAT) cycles, feat_cnt=0.
- Addr 0x0421 = {count 3, sumX 300, sumY 30, sumZ 3000} -> one feature: index 0x0421, count 3, means 100/10/1000.
- Addr 0 and addr 0x7FFF non-empty -> two features in order 0 then 0x7FFF, feat_cnt=2, done.
- count 1, sumX 5000 -> meanX saturates to 1023.
- feat_ready held low 50 cycles -> feat_data stable, no address advance; start pulsed meanwhile ignored.
- rst_n low during DIV -> all outputs at reset values immediately, no done; with VGR_CLEAR_ON_READ_EN, a full scan leaves every BRAM word zero.
